// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-side memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH_WORDS = 1024;
  localparam int DEFAULT_WAIT_CYCLES = 2;
  localparam int LANE_W              = 2;
  localparam logic [23:0] BYTE_ZEXT  = 24'h000000;

  // Byte loads return the addressed little-endian lane, zero-extended.
  function automatic logic [31:0] format_load(input logic [31:0] word,
                                              input logic [LANE_W-1:0] lane,
                                              input logic is_byte);
    logic [7:0] sel;
    sel = word[8*lane +: 8];
    return is_byte ? {BYTE_ZEXT, sel} : word;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32, byte-lane write enables
// and a registered read port (read-before-write on a shared access).
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder with programmable wait states in front of dmem_array.
// Define DMEM_ERR_EN to enable misalignment / out-of-range fault reporting.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic              byte_acc,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ack,
  output logic [31:0]       rdata,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state;
  logic [3:0]        cnt;
  logic              we_q;
  logic              byte_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rdata_hold;

  logic              acc_we;
  logic              acc_byte;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [LANE_W-1:0] acc_lane;
  logic              commit;
  logic              fault;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;
  logic [31:0]       resp_data;

  // With zero wait states the access commits on the accept edge itself,
  // so the live request fields are used instead of the captured copies.
  always_comb begin
    acc_we    = we_q;
    acc_byte  = byte_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state == ST_IDLE) begin
      acc_we    = we;
      acc_byte  = byte_acc;
      acc_addr  = addr;
      acc_wdata = wdata;
    end
  end

  assign acc_lane = acc_addr[LANE_W-1:0];
  assign commit   = ((state == ST_IDLE) && req && (WAIT_CYCLES == 0)) ||
                    ((state == ST_WAIT) && (cnt == 4'd1));

`ifdef DMEM_ERR_EN
  assign fault = (!acc_byte && (acc_lane != '0)) ||
                 (|acc_addr[ADDR_W-1:IDX_W+2]);
`else
  logic unused_addr_hi;
  assign fault          = 1'b0;
  assign unused_addr_hi = ^acc_addr[ADDR_W-1:IDX_W+2];
`endif

  always_comb begin
    ram_be = 4'h0;
    if (acc_we && !fault) ram_be = acc_byte ? (4'b0001 << acc_lane) : 4'hF;
  end

  assign ram_wdata = acc_byte ? {4{acc_wdata[7:0]}} : acc_wdata;

  // A reset on the commit edge aborts the access, so the RAM is gated too.
  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .en   (commit && !rst),
    .be   (ram_be),
    .idx  (acc_addr[IDX_W+1:2]),
    .wdata(ram_wdata),
    .rdata(ram_q)
  );

  // Stores leave the previous load data visible; faults force zero.
  always_comb begin
    resp_data = rdata_hold;
    if (err_q)      resp_data = 32'h0;
    else if (!we_q) resp_data = format_load(ram_q, addr_q[LANE_W-1:0], byte_q);
  end

  assign rdata = (state == ST_RESP) ? resp_data : rdata_hold;
  assign err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      ack        <= 1'b0;
      err_q      <= 1'b0;
      busy       <= 1'b0;
      rdata_hold <= 32'h0;
    end else begin
      ack   <= 1'b0;
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            we_q    <= we;
            byte_q  <= byte_acc;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt     <= WAIT_INIT;
            busy    <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
              ack   <= 1'b1;
              err_q <= fault;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= ST_RESP;
            ack   <= 1'b1;
            err_q <= fault;
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          rdata_hold <= resp_data;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
